// File: rtl/decoder_seq_pkg.sv
// Shared constants for the registered select/strobe decoder:
// command mode encodings and FSM state encodings.
package decoder_pkg;

  // Command modes, sampled from the bus on accept
  localparam logic [1:0] MODE_LATCH = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;
  localparam logic [1:0] MODE_THERM = 2'b11;

  // FSM states
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] HOLD  = 2'b01;
  localparam logic [1:0] PULSE = 2'b10;
  localparam logic [1:0] SCAN  = 2'b11;

endpackage

// File: rtl/decoder_seq_if.sv
// Command/select bus for decoder_seq. The master side issues indexed
// commands through a valid/ready handshake and observes the select lines.
interface decoder_seq_if #(
  parameter int IN_W    = 2,
  parameter int NUM_OUT = 4
);
  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_idx;
  logic [NUM_OUT-1:0] out;
  logic               out_valid;
  logic               err;
  logic               busy;

  modport master (
    output mode, in_valid, in_idx,
    input  in_ready, out, out_valid, err, busy
  );

  modport slave (
    input  mode, in_valid, in_idx,
    output in_ready, out, out_valid, err, busy
  );
endinterface

// File: rtl/decoder_seq_onehot_gen.sv
// Combinational index-to-pattern generator: one-hot (bit idx set) or
// thermometer (bits idx..0 set). Shared by command load and scan step.
module onehot_gen #(
  parameter int IN_W    = 2,
  parameter int NUM_OUT = 4
) (
  input  logic [IN_W-1:0]    idx_i,
  input  logic               therm_i,
  output logic [NUM_OUT-1:0] pat_o
);

  // Per-bit compare against the index; NUM_OUT <= 2^IN_W so i fits in IN_W bits
  always_comb begin
    pat_o = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (therm_i) begin
        pat_o[i] = (IN_W'(i) <= idx_i);
      end else begin
        pat_o[i] = (IN_W'(i) == idx_i);
      end
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered select/strobe generator: latched one-hot, timed pulse,
// auto-advancing scan and latched thermometer, with index range check.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int IN_W      = 2,
  parameter int NUM_OUT   = 4,
  parameter int PULSE_LEN = 3
) (
  input  logic         clk,
  input  logic         reset,
  decoder_seq_if.slave bus
);

  localparam int              CNT_W     = $clog2(PULSE_LEN + 1);
  localparam logic [IN_W-1:0] LAST_POS  = IN_W'(NUM_OUT - 1);
  // One extra bit so NUM_OUT == 2^IN_W is representable
  localparam logic [IN_W:0]   NUM_OUT_W = (IN_W + 1)'(NUM_OUT);

  logic [1:0]         state_q, state_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    pos_q, pos_d;

  logic               accept_s;
  logic               in_range_s;
  logic [IN_W-1:0]    step_pos_s;
  logic [IN_W-1:0]    gen_idx_s;
  logic               gen_therm_s;
  logic [NUM_OUT-1:0] gen_pat_s;

  assign bus.in_ready  = (state_q != PULSE);
  assign accept_s      = bus.in_valid && bus.in_ready;
  assign in_range_s    = ({1'b0, bus.in_idx} < NUM_OUT_W);
  // Scan wraps at the last real output, not at the top of the index space
  assign step_pos_s    = (pos_q == LAST_POS) ? '0 : pos_q + IN_W'(1);

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

  // Generator input: the new command on accept, otherwise the next scan slot
  always_comb begin
    gen_idx_s   = step_pos_s;
    gen_therm_s = 1'b0;
    if (accept_s) begin
      gen_idx_s   = bus.in_idx;
      gen_therm_s = (bus.mode == MODE_THERM);
    end else begin
      gen_idx_s   = step_pos_s;
      gen_therm_s = 1'b0;
    end
  end

  onehot_gen #(
    .IN_W    (IN_W),
    .NUM_OUT (NUM_OUT)
  ) u_gen (
    .idx_i   (gen_idx_s),
    .therm_i (gen_therm_s),
    .pat_o   (gen_pat_s)
  );

  // Next-state logic: command accept has priority, otherwise advance the current state
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    if (accept_s) begin
      if (!in_range_s) begin
        // Out-of-range command is consumed; mode is ignored
        state_d     = IDLE;
        out_d       = '0;
        out_valid_d = 1'b0;
        err_d       = 1'b1;
        busy_d      = 1'b0;
        cnt_d       = '0;
      end else begin
        out_d       = gen_pat_s;
        out_valid_d = 1'b1;
        pos_d       = bus.in_idx;
        busy_d      = 1'b0;
        cnt_d       = '0;
        case (bus.mode)
          MODE_LATCH: state_d = HOLD;
          MODE_THERM: state_d = HOLD;
          MODE_PULSE: begin
            state_d = PULSE;
            busy_d  = 1'b1;
            cnt_d   = CNT_W'(PULSE_LEN);
          end
          MODE_SCAN:  state_d = SCAN;
          default:    state_d = IDLE;
        endcase
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        HOLD: state_d = HOLD;
        PULSE: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d     = IDLE;
            out_d       = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        SCAN: begin
          pos_d = step_pos_s;
          out_d = gen_pat_s;
        end
        default: begin
          state_d     = IDLE;
          out_d       = '0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          cnt_d       = '0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      pos_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
    end
  end

endmodule
